sgb_pkt_tx: RTL and testbench

//  GB-side Super Game Boy command packet transmitter, the sending end of the ICD2 P14/P15 packet link.

---
 rtl/sgb_pkg.sv | 29 ++
 rtl/sgb_pkt_tick_timer.sv | 37 +++
 rtl/sgb_pkt_tx.sv | 214 +++++++++++++++++++++
 tb/tb_sgb_pkt_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgb_pkg.sv
// Shared definitions for the Super Game Boy packet link: FSM states, P14/P15 line codes
// and buffer geometry.
package sgb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRstLo,
    StRstHi,
    StBitLo,
    StBitHi,
    StStopLo,
    StStopHi
  } sgb_state_e;

  // {P15,P14} drive values, active low
  localparam logic [1:0] P54_IDLE = 2'b11;
  localparam logic [1:0] P54_RST  = 2'b00;
  localparam logic [1:0] P54_B0   = 2'b10;
  localparam logic [1:0] P54_B1   = 2'b01;

  localparam int unsigned SGB_PKT_BYTES = 16;
  localparam int unsigned SGB_PKT_MAX   = 8;

  // Line code for one data bit: '0' pulls P14 low, '1' pulls P15 low
  function automatic logic [1:0] sgb_bit_code(input logic b);
    return b ? P54_B1 : P54_B0;
  endfunction

endpackage

// File: rtl/sgb_pkt_tick_timer.sv
// Loadable down-counter paced by a tick strobe. A load always wins; otherwise the count
// decrements on each tick until it reaches zero and then holds.
module sgb_pkt_tick_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_ce_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: load has priority, then tick-paced decrement saturating at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_ce_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sgb_pkt_tx.sv
// GB-side Super Game Boy command packet transmitter. Sends reset pulse, 128 data bits
// (byte 0 first, LSB first) and a '0' stop bit over P14/P15, each pulse followed by a gap.
// Optional feature macro SGB_PKT_MULTI_EN: 8x16-byte buffer and multi-packet sends, the
// packet count taken from byte 0 of packet 0 (bits [2:0], 0 treated as 1).
module sgb_pkt_tx
  import sgb_pkg::*;
#(
  parameter int unsigned RESET_TICKS = 5,
  parameter int unsigned PULSE_TICKS = 5,
  parameter int unsigned GAP_TICKS   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ce_i,
  input  logic       buf_wr_i,
  input  logic [6:0] buf_addr_i,
  input  logic [7:0] buf_data_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] pkt_idx_o,
  output logic [1:0] p54_out_o,
  output logic       p54_oe_o
);

  localparam int unsigned TickMax =
      (RESET_TICKS > PULSE_TICKS) ?
      ((RESET_TICKS > GAP_TICKS) ? RESET_TICKS : GAP_TICKS) :
      ((PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS);
  // Counter only ever holds TICKS-1
  localparam int unsigned CntW = (TickMax > 2) ? $clog2(TickMax) : 1;

  localparam logic [CntW-1:0] RstLoad   = CntW'(RESET_TICKS - 1);
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_TICKS - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_TICKS - 1);

`ifdef SGB_PKT_MULTI_EN
  localparam int unsigned BufAddrW = 7;
`else
  localparam int unsigned BufAddrW = 4;
`endif
  localparam int unsigned BufDepth = 1 << BufAddrW;

  sgb_state_e state_q, state_d;
  logic [6:0] ptr_q, ptr_d;
  logic [2:0] pkt_idx_q, pkt_idx_d;
  logic       done_q, done_d;

  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_zero;
  logic            tick_done;

  logic [7:0]          buf_q [BufDepth];
  logic [BufAddrW-1:0] wr_addr;
  logic [BufAddrW-1:0] rd_addr;
  logic [7:0]          rd_byte;
  logic                cur_bit;
  logic                last_pkt;

`ifdef SGB_PKT_MULTI_EN
  logic [2:0] pkt_cnt;

  assign wr_addr  = buf_addr_i;
  assign rd_addr  = {pkt_idx_q, ptr_q[6:3]};
  assign pkt_cnt  = (buf_q[0][2:0] == 3'd0) ? 3'd1 : buf_q[0][2:0];
  assign last_pkt = (({1'b0, pkt_idx_q} + 4'd1) >= {1'b0, pkt_cnt});
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^buf_addr_i[6:4];
  assign wr_addr        = buf_addr_i[3:0];
  assign rd_addr        = ptr_q[6:3];
  assign last_pkt       = 1'b1;
`endif

  assign rd_byte = buf_q[rd_addr];
  assign cur_bit = rd_byte[ptr_q[2:0]];

  // Packet buffer: writes only land while idle so an in-flight packet cannot change
  always_ff @(posedge clk) begin
    if (buf_wr_i && (state_q == StIdle)) begin
      buf_q[wr_addr] <= buf_data_i;
    end
  end

  sgb_pkt_tick_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_ce_i  (tick_ce_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign tick_done = tick_ce_i & tmr_zero;

  // Next-state logic: abort beats everything, each phase ends on a tick with the count at zero
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pkt_idx_d = pkt_idx_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    if (abort_i) begin
      state_d   = StIdle;
      pkt_idx_d = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d   = StRstLo;
            ptr_d     = 7'd0;
            pkt_idx_d = 3'd0;
            tmr_load  = 1'b1;
            tmr_val   = RstLoad;
          end
        end
        StRstLo: begin
          if (tick_done) begin
            state_d  = StRstHi;
            tmr_load = 1'b1;
            tmr_val  = GapLoad;
          end
        end
        StRstHi: begin
          if (tick_done) begin
            state_d  = StBitLo;
            tmr_load = 1'b1;
            tmr_val  = PulseLoad;
          end
        end
        StBitLo: begin
          if (tick_done) begin
            state_d  = StBitHi;
            tmr_load = 1'b1;
            tmr_val  = GapLoad;
          end
        end
        StBitHi: begin
          if (tick_done) begin
            // Pointer wraps 127 -> 0 on the last bit, ready for the next packet
            ptr_d    = ptr_q + 7'd1;
            state_d  = (ptr_q == 7'd127) ? StStopLo : StBitLo;
            tmr_load = 1'b1;
            tmr_val  = PulseLoad;
          end
        end
        StStopLo: begin
          if (tick_done) begin
            state_d  = StStopHi;
            tmr_load = 1'b1;
            tmr_val  = GapLoad;
          end
        end
        StStopHi: begin
          if (tick_done) begin
            if (last_pkt) begin
              state_d   = StIdle;
              pkt_idx_d = 3'd0;
              done_d    = 1'b1;
            end else begin
              state_d   = StRstLo;
              pkt_idx_d = pkt_idx_q + 3'd1;
              ptr_d     = 7'd0;
              tmr_load  = 1'b1;
              tmr_val   = RstLoad;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM, bit pointer, packet index and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 7'd0;
      pkt_idx_q <= 3'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pkt_idx_q <= pkt_idx_d;
      done_q    <= done_d;
    end
  end

  // Line drive decoded from state so an async reset idles the link without a clock edge
  always_comb begin
    p54_out_o = P54_IDLE;
    unique case (state_q)
      StRstLo:  p54_out_o = P54_RST;
      StBitLo:  p54_out_o = sgb_bit_code(cur_bit);
      StStopLo: p54_out_o = P54_B0;
      default:  p54_out_o = P54_IDLE;
    endcase
  end

  assign busy_o    = (state_q != StIdle);
  assign p54_oe_o  = busy_o;
  assign done_o    = done_q;
  assign pkt_idx_o = pkt_idx_q;

endmodule

// File: tb/tb_sgb_pkt_tx.sv
// Bench for sgb_pkt_tx: two instances (unit ticks and default ticks) share stimulus,
// selected by sel. A line monitor turns P14/P15 into (value, length) runs which are
// compared against the packet waveform built from the buffer contents.
module tb_sgb_pkt_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tick_ce, buf_wr, start, abort, sel;
  logic [6:0] buf_addr;
  logic [7:0] buf_data;

  logic       f_busy, f_done, f_oe, d_busy, d_done, d_oe;
  logic [1:0] f_p54, d_p54;
  logic [2:0] f_pkt, d_pkt;

  logic       busy, done, oe;
  logic [1:0] p54;
  logic [2:0] pkt_idx;

  sgb_pkt_tx #(
    .RESET_TICKS (1),
    .PULSE_TICKS (1),
    .GAP_TICKS   (1)
  ) u_fast (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_ce_i  (tick_ce),
    .buf_wr_i   (buf_wr & sel),
    .buf_addr_i (buf_addr),
    .buf_data_i (buf_data),
    .start_i    (start & sel),
    .abort_i    (abort & sel),
    .busy_o     (f_busy),
    .done_o     (f_done),
    .pkt_idx_o  (f_pkt),
    .p54_out_o  (f_p54),
    .p54_oe_o   (f_oe)
  );

  sgb_pkt_tx u_dflt (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_ce_i  (tick_ce),
    .buf_wr_i   (buf_wr & ~sel),
    .buf_addr_i (buf_addr),
    .buf_data_i (buf_data),
    .start_i    (start & ~sel),
    .abort_i    (abort & ~sel),
    .busy_o     (d_busy),
    .done_o     (d_done),
    .pkt_idx_o  (d_pkt),
    .p54_out_o  (d_p54),
    .p54_oe_o   (d_oe)
  );

  assign busy    = sel ? f_busy : d_busy;
  assign done    = sel ? f_done : d_done;
  assign oe      = sel ? f_oe   : d_oe;
  assign p54     = sel ? f_p54  : d_p54;
  assign pkt_idx = sel ? f_pkt  : d_pkt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tick strobe: one clk high every tick_per clks
  int tick_per = 1;
  int tick_phase = 0;
  initial begin
    tick_ce = 1'b0;
    forever begin
      @(negedge clk);
      tick_ce = (tick_phase == 0);
      tick_phase = (tick_phase + 1 >= tick_per) ? 0 : tick_phase + 1;
    end
  end

  // Line monitor
  logic [1:0] run_val[$];
  int         run_len[$];
  logic [1:0] cur_val;
  int         cur_len;
  bit         in_pkt = 1'b0;
  int         pkt_end_cnt = 0;
  int         done_cnt = 0;
  bit         done_at_end = 1'b0;

  always @(posedge clk) begin
    #1;
    if (oe === 1'b1) begin
      if (!in_pkt) begin
        in_pkt  = 1'b1;
        cur_val = p54;
        cur_len = 1;
      end else if (p54 == cur_val) begin
        cur_len++;
      end else begin
        run_val.push_back(cur_val);
        run_len.push_back(cur_len);
        cur_val = p54;
        cur_len = 1;
      end
    end else if (in_pkt) begin
      run_val.push_back(cur_val);
      run_len.push_back(cur_len);
      in_pkt = 1'b0;
      pkt_end_cnt++;
      if (done === 1'b1) done_at_end = 1'b1;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_mon();
    run_val.delete();
    run_len.delete();
    pkt_end_cnt = 0;
    done_cnt    = 0;
    done_at_end = 1'b0;
    in_pkt      = 1'b0;
  endtask

  // Reference buffer and expected waveform (value, length in ticks)
  logic [7:0] mdl[16];
  logic [1:0] exp_val[$];
  int         exp_tk[$];

  task automatic build_exp(input int rt, input int pt, input int gt);
    logic b;
    exp_val.delete();
    exp_tk.delete();
    exp_val.push_back(2'b00); exp_tk.push_back(rt);
    exp_val.push_back(2'b11); exp_tk.push_back(gt);
    for (int k = 0; k < 128; k++) begin
      b = mdl[k / 8][k % 8];
      exp_val.push_back(b ? 2'b01 : 2'b10); exp_tk.push_back(pt);
      exp_val.push_back(2'b11);             exp_tk.push_back(gt);
    end
    exp_val.push_back(2'b10); exp_tk.push_back(pt);
    exp_val.push_back(2'b11); exp_tk.push_back(gt);
  endtask

  task automatic write_byte(input int a, input logic [7:0] d);
    @(negedge clk);
    buf_wr   = 1'b1;
    buf_addr = a[6:0];
    buf_data = d;
    @(negedge clk);
    buf_wr = 1'b0;
  endtask

  // mode 0: 0x00..0x0F, 1: all 0xFF, 2: random
  task automatic fill_buf(input int mode);
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      v = (mode == 0) ? 8'(i) : (mode == 1) ? 8'hFF : 8'($urandom);
      mdl[i] = v;
      write_byte(i, v);
    end
  endtask

  task automatic pulse_start(input bit with_wr, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    if (with_wr) begin
      buf_wr   = 1'b1;
      buf_addr = 7'd0;
      buf_data = d;
    end
    @(negedge clk);
    start  = 1'b0;
    buf_wr = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int c = 0;
    while (pkt_end_cnt == 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_packet(input string tag, input int rt, input int pt, input int gt,
                              input int n);
    int lo, hi, last;
    logic [7:0] dec;
    build_exp(rt, pt, gt);
    check_eq({tag, " pkt_end"}, pkt_end_cnt, 1);
    check_eq({tag, " runs"}, run_val.size(), exp_val.size());
    if (run_val.size() == exp_val.size()) begin
      lo = (rt - 1) * n + 1;
      hi = rt * n;
      check_eq({tag, " rst_val"}, run_val[0], 2'b00);
      check_eq({tag, " rst_len_ok"}, (run_len[0] >= lo) && (run_len[0] <= hi), 1);
      last = run_val.size() - 1;
      for (int i = 1; i <= last; i++) begin
        if (run_val[i] !== exp_val[i] || run_len[i] != exp_tk[i] * n || i == last) begin
          check_eq({tag, " run_val"}, run_val[i], exp_val[i]);
          check_eq({tag, " run_len"}, run_len[i], exp_tk[i] * n);
          break;
        end
      end
      for (int by = 0; by < 16; by++) begin
        dec = '0;
        for (int bi = 0; bi < 8; bi++) dec[bi] = (run_val[2 + 2 * (by * 8 + bi)] == 2'b01);
        check_eq({tag, " byte"}, dec, mdl[by]);
      end
    end
    check_eq({tag, " done_cnt"}, done_cnt, 1);
    check_eq({tag, " done_at_end"}, done_at_end, 1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " p54"}, p54, 2'b11);
    check_eq({tag, " oe"}, oe, 1'b0);
    check_eq({tag, " busy"}, busy, 1'b0);
    check_eq({tag, " done"}, done, 1'b0);
  endtask

  initial begin
    int n, c;
    bit wr;
    logic [7:0] nd;
    rst_n = 1'b0; sel = 1'b1; start = 1'b0; abort = 1'b0;
    buf_wr = 1'b0; buf_addr = '0; buf_data = '0;
    repeat (3) @(negedge clk);
    check_idle("reset fast");
    check_eq("reset fast pkt_idx", pkt_idx, 3'd0);
    sel = 1'b0;
    #1;
    check_idle("reset dflt");
    check_eq("reset dflt pkt_idx", pkt_idx, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unit ticks, counting pattern
    sel = 1'b1; tick_per = 1; tick_phase = 0;
    fill_buf(0);
    clear_mon();
    pulse_start(1'b0, 8'h00);
    wait_end(2000);
    check_packet("t1", 1, 1, 1, 1);

    // Default ticks, all ones, tick every 4 clks
    sel = 1'b0; tick_per = 4; tick_phase = 0;
    fill_buf(1);
    clear_mon();
    pulse_start(1'b0, 8'h00);
    wait_end(20000);
    check_packet("t2", 5, 5, 15, 4);

    // Randomized packets, sometimes writing byte 0 in the start clk
    sel = 1'b1;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 4);
      tick_per = n; tick_phase = 0;
      fill_buf(2);
      wr = 1'($urandom_range(0, 1));
      nd = 8'($urandom);
      if (wr) mdl[0] = nd;
      clear_mon();
      pulse_start(wr, nd);
      wait_end(4000);
      check_packet("rnd", 1, 1, 1, n);
    end
    sel = 1'b0; tick_per = 1; tick_phase = 0;
    fill_buf(2);
    clear_mon();
    pulse_start(1'b0, 8'h00);
    wait_end(6000);
    check_packet("rnd_dflt", 5, 5, 15, 1);

    // Abort during bit 37
    sel = 1'b1; tick_per = 2; tick_phase = 0;
    fill_buf(2);
    clear_mon();
    pulse_start(1'b0, 8'h00);
    c = 0;
    while (run_val.size() < 76 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check_eq("t3 at bit37", (run_val.size() == 76) && (cur_val != 2'b11), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("t3 abort");
    repeat (5) @(negedge clk);
    check_eq("t3 no done", done_cnt, 0);
    clear_mon();
    pulse_start(1'b0, 8'h00);
    wait_end(4000);
    check_packet("t3 restart", 1, 1, 1, 2);

    // start and buf_wr while busy are ignored
    fill_buf(2);
    clear_mon();
    pulse_start(1'b0, 8'h00);
    c = 0;
    while (run_val.size() < 20 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    pulse_start(1'b0, 8'h00);
    write_byte(5, ~mdl[5]);
    wait_end(4000);
    check_packet("t4", 1, 1, 1, 2);
    repeat (10) @(negedge clk);
    check_eq("t4 stays idle", oe, 1'b0);
    check_eq("t4 one done", done_cnt, 1);

    // Async reset during BIT_LO
    tick_per = 3; tick_phase = 0;
    clear_mon();
    pulse_start(1'b0, 8'h00);
    c = 0;
    while (!(run_val.size() >= 10 && in_pkt && cur_val != 2'b11 && p54 != 2'b11) && c < 2000)
    begin
      @(negedge clk);
      c++;
    end
    check_eq("t5 in bit_lo", oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t5 async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5 idle after", busy, 1'b0);
    check_eq("t5 pkt_idx", pkt_idx, 3'd0);
    clear_mon();
    pulse_start(1'b0, 8'h00);
    wait_end(4000);
    check_packet("t5 restart", 1, 1, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
